// File: rtl/spinner_multi_if.sv
// Spinner control bundle: per-channel buttons, analog deltas, preset
// and the angle outputs back to the game core.
interface spinner_multi_if #(
  parameter int CHANNELS = 2,
  parameter int ANGLE_W  = 4
);
  logic                          strobe;
  logic [CHANNELS-1:0]           minus;
  logic [CHANNELS-1:0]           plus;
  logic [CHANNELS-1:0]           fast;
  logic [9*CHANNELS-1:0]         spin_in;
  logic [CHANNELS-1:0]           preset;
  logic [ANGLE_W-1:0]            preset_val;
  logic [ANGLE_W*CHANNELS-1:0]   spin_out;

  modport master (
    output strobe, minus, plus, fast,
    output spin_in, preset, preset_val,
    input  spin_out
  );

  modport slave (
    input  strobe, minus, plus, fast,
    input  spin_in, preset, preset_val,
    output spin_out
  );
endinterface

// File: rtl/spinner_multi.sv
// Multi-channel spinner position generator: digital buttons plus
// analog deltas into a fractional per-channel position.
module spinner_multi #(
  parameter int CHANNELS = 2,
  parameter int ANGLE_W  = 4,
  parameter int FRAC_W   = 3,
  parameter int SLOW_DIV = 2,
  parameter int FAST_DIV = 1,
  parameter int CLAMP    = 0
) (
  input  logic clk_sys,
  input  logic reset_n,
  spinner_multi_if.slave io
);
  localparam int P    = ANGLE_W + FRAC_W;
  // Extra headroom so pos + step + full analog delta never overflows
  localparam int SW   = (P + 2 > 10) ? P + 2 : 10;
  localparam int DMAX = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  localparam logic signed [SW-1:0] STEP = SW'(1 << FRAC_W);
  localparam logic signed [SW-1:0] PMAX = SW'((1 << P) - 1);
  localparam logic [CW-1:0] RL_F = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0] RL_S = CW'(SLOW_DIV - 1);

  logic r_strobe_d;
  logic r_edge;
  logic r_armed;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_strobe_d <= 1'b0;
      r_edge     <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_strobe_d <= io.strobe;
      r_edge     <= io.strobe & ~r_strobe_d;
      r_armed    <= 1'b1;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [P-1:0]         r_pos;
    logic [CW-1:0]        r_cnt;
    logic                 r_tog;
    logic                 w_dir;
    logic                 w_dstep;
    logic                 w_aevt;
    logic signed [SW-1:0] w_d;
    logic signed [SW-1:0] w_a;
    logic signed [SW-1:0] w_sum;
    logic [P-1:0]         w_next;

    assign w_dir   = io.plus[k] ^ io.minus[k];
    assign w_dstep = w_dir & r_edge & (r_cnt == '0);
    assign w_aevt  = r_armed & (io.spin_in[9*k+8] != r_tog);

    always_comb begin
      w_d = '0;
      if (w_dstep) w_d = io.plus[k] ? STEP : -STEP;
      w_a = '0;
      if (w_aevt)
        w_a = {{(SW-8){io.spin_in[9*k+7]}},
               io.spin_in[9*k +: 8]};
      w_sum  = $signed({{(SW-P){1'b0}}, r_pos}) + w_d + w_a;
      w_next = w_sum[P-1:0];
      if (CLAMP != 0) begin
        if (w_sum[SW-1])       w_next = '0;
        else if (w_sum > PMAX) w_next = '1;
      end
      if (io.preset[k])
        w_next = {io.preset_val, {FRAC_W{1'b0}}};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        r_pos <= '0;
        r_cnt <= '0;
        r_tog <= 1'b0;
      end else begin
        r_tog <= io.spin_in[9*k+8];
        r_pos <= w_next;
        if (!w_dir)
          r_cnt <= '0;
        else if (r_edge) begin
          if (r_cnt == '0) r_cnt <= io.fast[k] ? RL_F : RL_S;
          else             r_cnt <= r_cnt - CW'(1);
        end
      end
    end

    assign io.spin_out[k*ANGLE_W +: ANGLE_W] = r_pos[P-1:FRAC_W];
  end
endmodule
